// File: rtl/alu_reg_pkg.sv
// Shared constants for the 4-bit ALU / register slice: datapath width and ALU opcodes.
package alu_reg_pkg;

    localparam int W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

endpackage : alu_reg_pkg

// File: rtl/alu_core.sv
// Purely combinational 8-operation ALU. Every result is unsigned and truncated to W bits.
module alu_core
    import alu_reg_pkg::*;
(
    input  logic [2:0]   oc_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] f_o
);

    // Select the result for the current opcode; a zero divisor yields zero, never X.
    always_comb begin
        // NOTE: f_o gets a default before the case so no path can leave it unassigned and infer a latch.
        f_o = '0;
        unique case (oc_i)
            OP_ADD: f_o = a_i + b_i;
            OP_SUB: f_o = a_i - b_i;
            OP_MUL: f_o = a_i * b_i;
            OP_DIV: f_o = (b_i == '0) ? '0 : (a_i / b_i);
            OP_NOT: f_o = ~a_i;
            OP_XOR: f_o = a_i ^ b_i;
            OP_OR:  f_o = a_i | b_i;
            OP_AND: f_o = a_i & b_i;
            default: f_o = '0;
        endcase
    end

endmodule : alu_core

// File: rtl/shift_reg4.sv
// 4-bit multi-function register: clear, load, increment, decrement, shift right/left with
// serial fill. One action per edge, priority cl > ld > inc > dec > sr > sl > hold.
module shift_reg4
    import alu_reg_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         cl_i,
    input  logic         ld_i,
    input  logic [W-1:0] in_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         sr_i,
    input  logic         ir_i,
    input  logic         sl_i,
    input  logic         il_i,
    output logic [W-1:0] out_o
);

    logic [W-1:0] out_q;
    logic [W-1:0] out_d;

    // Pick exactly one action by fixed priority; lower-priority controls are ignored.
    always_comb begin
        out_d = out_q;
        if (cl_i) begin
            out_d = '0;
        end else if (ld_i) begin
            out_d = in_i;
        end else if (inc_i) begin
            out_d = out_q + 1'b1;
        end else if (dec_i) begin
            out_d = out_q - 1'b1;
        end else if (sr_i) begin
            out_d = {ir_i, out_q[W-1:1]};
        end else if (sl_i) begin
            out_d = {out_q[W-2:0], il_i};
        end
    end

    // State register; reset clears it immediately, independent of the clock.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_o = out_q;

endmodule : shift_reg4

// File: rtl/alu_reg_unit.sv
// Datapath slice: independent combinational ALU and 4-bit multi-function register.
module alu_reg_unit
    import alu_reg_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   oc,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] f,
    input  logic         cl,
    input  logic         ld,
    input  logic [W-1:0] in,
    input  logic         inc,
    input  logic         dec,
    input  logic         sr,
    input  logic         ir,
    input  logic         sl,
    input  logic         il,
    output logic [W-1:0] out
);

    alu_core u_alu (
        .oc_i (oc),
        .a_i  (a),
        .b_i  (b),
        .f_o  (f)
    );

    shift_reg4 u_reg (
        .clk   (clk),
        .rst   (rst),
        .cl_i  (cl),
        .ld_i  (ld),
        .in_i  (in),
        .inc_i (inc),
        .dec_i (dec),
        .sr_i  (sr),
        .ir_i  (ir),
        .sl_i  (sl),
        .il_i  (il),
        .out_o (out)
    );

endmodule : alu_reg_unit

// File: tb/tb_alu_reg_unit.sv
// Self-checking bench for alu_reg_unit: directed ALU vectors, exhaustive ALU sweep against an
// arithmetic model, directed register sequences, and randomized register traffic.
module tb_alu_reg_unit;
    import alu_reg_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] oc;
    logic [3:0] a, b, f;
    logic       cl, ld, inc, dec, sr, ir, sl, il;
    logic [3:0] in, out;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] oc;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] f;
    } alu_vec_t;

    typedef struct packed {
        logic       cl, ld, inc, dec, sr, ir, sl, il;
        logic [3:0] din;
    } ctrl_t;

    alu_reg_unit dut (
        .clk (clk), .rst (rst),
        .oc  (oc),  .a   (a),   .b  (b),  .f (f),
        .cl  (cl),  .ld  (ld),  .in (in),
        .inc (inc), .dec (dec),
        .sr  (sr),  .ir  (ir),  .sl (sl), .il (il),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ALU reference: plain integer arithmetic reduced modulo 16.
    function automatic int alu_model(input int op, input int av, input int bv);
        case (op)
            0: return (av + bv) % 16;
            1: return (av - bv + 16) % 16;
            2: return (av * bv) % 16;
            3: return (bv == 0) ? 0 : av / bv;
            4: return 15 - av;
            5: return av ^ bv;
            6: return av | bv;
            default: return av & bv;
        endcase
    endfunction

    // Register reference: first asserted control in priority order wins.
    function automatic int reg_model(input int cur, input ctrl_t c);
        if (c.cl)  return 0;
        if (c.ld)  return int'(c.din);
        if (c.inc) return (cur + 1) % 16;
        if (c.dec) return (cur + 15) % 16;
        if (c.sr)  return (c.ir ? 8 : 0) + cur / 2;
        if (c.sl)  return (cur * 2) % 16 + (c.il ? 1 : 0);
        return cur;
    endfunction

    function automatic ctrl_t mk(input bit c_cl, input bit c_ld, input bit c_inc, input bit c_dec,
                                 input bit c_sr, input bit c_ir, input bit c_sl, input bit c_il,
                                 input logic [3:0] c_din);
        ctrl_t c;
        c = '{cl: c_cl, ld: c_ld, inc: c_inc, dec: c_dec, sr: c_sr, ir: c_ir, sl: c_sl, il: c_il,
              din: c_din};
        return c;
    endfunction

    task automatic drive(input ctrl_t c);
        cl = c.cl; ld = c.ld; inc = c.inc; dec = c.dec;
        sr = c.sr; ir = c.ir; sl = c.sl;   il = c.il;   in = c.din;
    endtask

    // Apply controls on the falling edge, sample just after the next rising edge.
    task automatic step(input ctrl_t c);
        @(negedge clk);
        drive(c);
        @(posedge clk);
        #1;
    endtask

    alu_vec_t vecs [8];
    ctrl_t    idle;
    ctrl_t    c;
    int       model_q;

    initial begin
        vecs[0] = '{oc: OP_ADD, a: 4'd9,  b: 4'd8,  f: 4'd1};
        vecs[1] = '{oc: OP_SUB, a: 4'd2,  b: 4'd5,  f: 4'd13};
        vecs[2] = '{oc: OP_MUL, a: 4'd7,  b: 4'd3,  f: 4'd5};
        vecs[3] = '{oc: OP_DIV, a: 4'd9,  b: 4'd0,  f: 4'd0};
        vecs[4] = '{oc: OP_DIV, a: 4'd15, b: 4'd4,  f: 4'd3};
        vecs[5] = '{oc: OP_NOT, a: 4'd5,  b: 4'd0,  f: 4'hA};
        vecs[6] = '{oc: OP_XOR, a: 4'hC,  b: 4'hA,  f: 4'h6};
        vecs[7] = '{oc: OP_AND, a: 4'hC,  b: 4'hA,  f: 4'h8};

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        drive(idle);
        oc = '0; a = '0; b = '0;
        rst = 1'b1;
        #3;
        check("reset_state", out, 4'h0);

        // Directed ALU vectors.
        for (int i = 0; i < 8; i++) begin
            oc = vecs[i].oc; a = vecs[i].a; b = vecs[i].b;
            #1;
            check($sformatf("alu_vec%0d", i), f, vecs[i].f);
            #1;
        end

        // Exhaustive ALU sweep, 2 time units per combination.
        for (int i = 0; i < 2048; i++) begin
            {oc, a, b} = i[10:0];
            #1;
            check($sformatf("alu_sweep oc=%0d a=%0d b=%0d", oc, a, b), f,
                  4'(alu_model(int'(oc), int'(a), int'(b))));
            #1;
        end

        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset between edges.
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 4'hA));
        check("load_A", out, 4'hA);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset", out, 4'h0);
        drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 4'h7));
        @(posedge clk);
        #1;
        check("reset_holds", out, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(0, 0, 1, 0, 0, 0, 0, 0, 4'h0));
        @(posedge clk);
        #1;
        check("first_edge_after_reset", out, 4'h1);

        // Priority.
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 4'h5));
        check("prio_load5", out, 4'h5);
        step(mk(1, 1, 1, 0, 0, 0, 0, 0, 4'h9));
        check("prio_cl", out, 4'h0);
        step(mk(0, 1, 1, 0, 0, 0, 0, 0, 4'h3));
        check("prio_ld", out, 4'h3);
        step(mk(0, 0, 1, 1, 0, 0, 0, 0, 4'h0));
        check("prio_inc", out, 4'h4);
        step(idle);
        check("hold", out, 4'h4);

        // Wrap.
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 4'hF));
        check("wrap_loadF", out, 4'hF);
        step(mk(0, 0, 1, 0, 0, 0, 0, 0, 4'h0));
        check("wrap_inc", out, 4'h0);
        step(mk(0, 0, 0, 1, 0, 0, 0, 0, 4'h0));
        check("wrap_dec", out, 4'hF);

        // Shifts.
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 4'b1001));
        check("shift_load", out, 4'b1001);
        step(mk(0, 0, 0, 0, 1, 1, 0, 0, 4'h0));
        check("shift_sr", out, 4'b1100);
        step(mk(0, 0, 0, 0, 0, 0, 1, 1, 4'h0));
        check("shift_sl", out, 4'b1001);
        step(mk(0, 0, 0, 0, 1, 0, 1, 1, 4'h0));
        check("shift_sr_wins", out, 4'b0100);

        // Randomized register traffic against the priority model.
        model_q = 4;
        for (int i = 0; i < 1000; i++) begin
            c = mk($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   4'($urandom_range(0, 15)));
            step(c);
            model_q = reg_model(model_q, c);
            check($sformatf("random%0d", i), out, 4'(model_q));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_reg_unit
